// File: rtl/operand_xfer_ram_pkg.sv
// Shared types and helpers for the word-to-operand transfer buffer.
// Holds the slot state encoding, the bus word size and the address decode
// that splits a flat word index into (slot, word-within-slot).
package rsa_xfer_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_LOADING = 2'd1,
        SLOT_ARMED   = 2'd2,
        SLOT_RESULT  = 2'd3
    } slot_state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = 32;

    typedef struct packed {
        int unsigned slot;
        int unsigned word;
    } xfer_loc_t;

    // Slots are laid out back to back, so the slot is the quotient and the
    // word is the remainder of the flat word index.
    function automatic xfer_loc_t decode_word_index(input int unsigned index,
                                                    input int unsigned wordsPerOp);
        xfer_loc_t loc;
        loc.slot = index / wordsPerOp;
        loc.word = index % wordsPerOp;
        return loc;
    endfunction

endpackage

// File: rtl/operand_xfer_ram_if.sv
// Bundles the software register bus and the per-core operand/result
// handshake of the transfer buffer. The master side is software plus the
// cores; the slave side is the buffer itself.
interface operand_xfer_ram_if #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int NUM_CORES       = 2,
    parameter int OPERAND_WIDTH   = 512
);
    import rsa_xfer_pkg::*;

    logic [BRAM_ADDR_WIDTH-1:0]         addr_sw;
    logic [WORD_BITS-1:0]               din_sw;
    logic                               we_sw;
    logic                               re_sw;
    logic [WORD_BITS-1:0]               dout_sw;
    logic [NUM_CORES*OPERAND_WIDTH-1:0] dout_hw;
    logic [NUM_CORES-1:0]               dout_hw_valid;
    logic [NUM_CORES*OPERAND_WIDTH-1:0] din_hw;
    logic [NUM_CORES-1:0]               din_hw_valid;
    logic [NUM_CORES-1:0]               din_hw_ready;
    logic [2*NUM_CORES-1:0]             slot_state;

    modport master (
        output addr_sw, din_sw, we_sw, re_sw, din_hw, din_hw_valid,
        input  dout_sw, dout_hw, dout_hw_valid, din_hw_ready, slot_state
    );

    modport slave (
        input  addr_sw, din_sw, we_sw, re_sw, din_hw, din_hw_valid,
        output dout_sw, dout_hw, dout_hw_valid, din_hw_ready, slot_state
    );

endinterface

// File: rtl/operand_xfer_ram_slot.sv
// One operand slot: the word registers presented to a core, the per-slot
// load/arm/result state machine, the arm pulse and the result-accept logic.
module operand_slot
    import rsa_xfer_pkg::*;
#(
    parameter int OPERAND_WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     swWrite_i,
    input  logic [31:0]              swWord_i,
    input  logic [WORD_BITS-1:0]     swData_i,
    input  logic                     swReadLast_i,
    input  logic [OPERAND_WIDTH-1:0] hwData_i,
    input  logic                     hwValid_i,
    output logic                     hwReady_o,
    output logic [OPERAND_WIDTH-1:0] data_o,
    output logic                     armPulse_o,
    output logic [1:0]               state_o
);

    localparam int WORDS_PER_OP = OPERAND_WIDTH / WORD_BITS;

    localparam logic [1:0] ST_IDLE    = SLOT_IDLE;
    localparam logic [1:0] ST_LOADING = SLOT_LOADING;
    localparam logic [1:0] ST_ARMED   = SLOT_ARMED;
    localparam logic [1:0] ST_RESULT  = SLOT_RESULT;

    logic [1:0]               state_q, state_d;
    logic [OPERAND_WIDTH-1:0] data_q, data_d;
    logic                     armPulse_q, armPulse_d;
    logic                     swLastWord;
    logic                     hwAccept;

    assign swLastWord = (swWord_i == 32'(WORDS_PER_OP - 1));

    // Software owns the slot whenever it writes to it, so a result is only
    // accepted from an armed slot in a cycle with no competing write.
    assign hwReady_o = resetn & (state_q == ST_ARMED) & ~swWrite_i;
    assign hwAccept  = hwValid_i & hwReady_o;

    // Next-state: a software write always lands and re-arms on the top word;
    // otherwise an accepted result replaces the whole operand, and reading
    // the top word of a result hands the slot back to idle.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        armPulse_d = 1'b0;
        if (swWrite_i) begin
            for (int w = 0; w < WORDS_PER_OP; w++) begin
                if (swWord_i == 32'(w)) begin
                    data_d[w*WORD_BITS +: WORD_BITS] = swData_i;
                end
            end
            if (swLastWord) begin
                state_d    = ST_ARMED;
                armPulse_d = 1'b1;
            end else begin
                state_d = ST_LOADING;
            end
        end else if (hwAccept) begin
            state_d = ST_RESULT;
            data_d  = hwData_i;
        end else if ((state_q == ST_RESULT) && swReadLast_i) begin
            state_d = ST_IDLE;
        end
    end

    // Slot registers; reset empties the operand and returns to idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            armPulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            armPulse_q <= armPulse_d;
        end
    end

    assign data_o     = data_q;
    assign armPulse_o = armPulse_q;
    assign state_o    = state_q;

endmodule

// File: rtl/operand_xfer_ram.sv
// Word-to-operand transfer buffer between the 32-bit software bus and
// NUM_CORES wide-operand cores. The top level only decodes the software
// address, steers it to one slot, and registers software read data.
module operand_xfer_ram
    import rsa_xfer_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int NUM_CORES       = 2,
    parameter int OPERAND_WIDTH   = 512
) (
    input  logic              clk,
    input  logic              resetn,
    operand_xfer_ram_if.slave bus
);

    localparam int WORDS_PER_OP = OPERAND_WIDTH / WORD_BITS;
    localparam int DEPTH        = NUM_CORES * WORDS_PER_OP;

    logic [31:0]          idx32;
    logic                 inRange;
    logic                 lastWordSel;
    xfer_loc_t            loc;
    logic [WORD_BITS-1:0] readWord;
    logic [WORD_BITS-1:0] dout_sw_q, dout_sw_d;

    assign idx32       = 32'(bus.addr_sw >> 2);
    assign inRange     = (idx32 < 32'(DEPTH));
    assign lastWordSel = (loc.word == 32'(WORDS_PER_OP - 1));

    // Split the flat word index into the target slot and word.
    always_comb begin
        loc = decode_word_index(idx32, WORDS_PER_OP);
    end

    // Read mux over the stored words; an index past the end reads zero.
    always_comb begin
        readWord = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (idx32 == 32'(k)) begin
                readWord = bus.dout_hw[k*WORD_BITS +: WORD_BITS];
            end
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        logic slotHit;
        assign slotHit = inRange & (loc.slot == 32'(i));

        operand_slot #(
            .OPERAND_WIDTH(OPERAND_WIDTH)
        ) u_slot (
            .clk         (clk),
            .resetn      (resetn),
            .swWrite_i   (bus.we_sw & slotHit),
            .swWord_i    (loc.word),
            .swData_i    (bus.din_sw),
            .swReadLast_i(bus.re_sw & slotHit & lastWordSel),
            .hwData_i    (bus.din_hw[i*OPERAND_WIDTH +: OPERAND_WIDTH]),
            .hwValid_i   (bus.din_hw_valid[i]),
            .hwReady_o   (bus.din_hw_ready[i]),
            .data_o      (bus.dout_hw[i*OPERAND_WIDTH +: OPERAND_WIDTH]),
            .armPulse_o  (bus.dout_hw_valid[i]),
            .state_o     (bus.slot_state[2*i +: 2])
        );
    end

    // Read data is captured on a read strike and then held, so it reflects
    // the contents before any write in the same cycle.
    always_comb begin
        dout_sw_d = bus.re_sw ? readWord : dout_sw_q;
    end

    // Software read-data register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout_sw_q <= '0;
        end else begin
            dout_sw_q <= dout_sw_d;
        end
    end

    assign bus.dout_sw = dout_sw_q;

endmodule

// File: tb/tb_operand_xfer_ram.sv
// Testbench for operand_xfer_ram: a 2-core/512-bit instance checked every
// cycle against a word-array model, plus a 1-core/32-bit instance for the
// single-word slot case, and directed scenarios with literal expectations.
module tb_operand_xfer_ram;
    import rsa_xfer_pkg::*;

    localparam int AW    = 10;
    localparam int NC    = 2;
    localparam int OW    = 512;
    localparam int WPO   = OW / 32;
    localparam int DEPTH = NC * WPO;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   checkEn = 1'b0;

    operand_xfer_ram_if #(.BRAM_ADDR_WIDTH(AW), .NUM_CORES(NC), .OPERAND_WIDTH(OW)) busA();
    operand_xfer_ram_if #(.BRAM_ADDR_WIDTH(AW), .NUM_CORES(1),  .OPERAND_WIDTH(32)) busB();

    operand_xfer_ram #(.BRAM_ADDR_WIDTH(AW), .NUM_CORES(NC), .OPERAND_WIDTH(OW)) dutA (
        .clk   (clk),
        .resetn(resetn),
        .bus   (busA)
    );

    operand_xfer_ram #(.BRAM_ADDR_WIDTH(AW), .NUM_CORES(1), .OPERAND_WIDTH(32)) dutB (
        .clk   (clk),
        .resetn(resetn),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    // Reference model: flat word memory, per-slot state number, last pulse
    // and the held read value.
    logic [31:0]   mMem [DEPTH];
    int            mState [NC];
    logic [NC-1:0] mPulse = '0;
    logic [31:0]   mDoutSw = '0;

    task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [NC*OW-1:0] expHw;
        logic [2*NC-1:0]  expState;
        logic [NC-1:0]    expReady;
        int               idx;
        int               bad;
        idx = int'(busA.addr_sw >> 2);
        for (int k = 0; k < DEPTH; k++) expHw[k*32 +: 32] = mMem[k];
        for (int s = 0; s < NC; s++) begin
            expState[2*s +: 2] = 2'(mState[s]);
            expReady[s] = resetn && (mState[s] == 2) &&
                          !(busA.we_sw && (idx < DEPTH) && (idx / WPO == s));
        end
        checks++;
        if (busA.dout_hw !== expHw) begin
            errors++;
            bad = 0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (busA.dout_hw[k*32 +: 32] !== expHw[k*32 +: 32]) bad = k;
            end
            $display("[TB] FAIL model_dout_hw word %0d: got %h, expected %h at %0t",
                     bad, busA.dout_hw[bad*32 +: 32], expHw[bad*32 +: 32], $time);
        end
        cmp32("model_slot_state", 32'(busA.slot_state), 32'(expState));
        cmp32("model_dout_hw_valid", 32'(busA.dout_hw_valid), 32'(mPulse));
        cmp32("model_din_hw_ready", 32'(busA.din_hw_ready), 32'(expReady));
        cmp32("model_dout_sw", busA.dout_sw, mDoutSw);
    endtask

    task automatic updateModel();
        int            idx;
        bit            inR;
        logic [NC-1:0] pulse;
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) mMem[k] = '0;
            for (int s = 0; s < NC; s++) mState[s] = 0;
            mPulse  = '0;
            mDoutSw = '0;
            return;
        end
        idx   = int'(busA.addr_sw >> 2);
        inR   = (idx < DEPTH);
        pulse = '0;
        if (busA.re_sw) mDoutSw = inR ? mMem[idx] : 32'h0;
        for (int s = 0; s < NC; s++) begin
            if (busA.we_sw && inR && (idx / WPO == s)) begin
                mMem[idx] = busA.din_sw;
                if (idx % WPO == WPO - 1) begin
                    mState[s] = 2;
                    pulse[s]  = 1'b1;
                end else begin
                    mState[s] = 1;
                end
            end else if (mState[s] == 2 && busA.din_hw_valid[s]) begin
                for (int w = 0; w < WPO; w++) mMem[s*WPO + w] = busA.din_hw[(s*WPO + w)*32 +: 32];
                mState[s] = 3;
            end else if (mState[s] == 3 && busA.re_sw && inR && idx == s*WPO + WPO - 1) begin
                mState[s] = 0;
            end
        end
        mPulse = pulse;
    endtask

    // Compare the wide instance against the model mid-cycle, then advance
    // the model with the inputs that the coming edge will see.
    always @(negedge clk) begin
        if (checkEn) checkOutput();
        updateModel();
    end

    task automatic tick();
        @(posedge clk);
        #1;
        busA.we_sw = 1'b0;
        busA.re_sw = 1'b0;
        busA.din_hw_valid = '0;
        busB.we_sw = 1'b0;
        busB.re_sw = 1'b0;
        busB.din_hw_valid = '0;
    endtask

    task automatic applyStimulus(input bit we, input bit re, input int addr, input logic [31:0] din,
                                 input logic [NC-1:0] hwValid, input logic [NC*OW-1:0] hwData);
        busA.we_sw        = we;
        busA.re_sw        = re;
        busA.addr_sw      = AW'(addr);
        busA.din_sw       = din;
        busA.din_hw_valid = hwValid;
        busA.din_hw       = hwData;
        #1;
    endtask

    initial begin
        logic [NC*OW-1:0] hw;
        busA.addr_sw = '0; busA.din_sw = '0; busA.we_sw = 1'b0; busA.re_sw = 1'b0;
        busA.din_hw = '0; busA.din_hw_valid = '0;
        busB.addr_sw = '0; busB.din_sw = '0; busB.we_sw = 1'b0; busB.re_sw = 1'b0;
        busB.din_hw = '0; busB.din_hw_valid = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        checkEn = 1'b1;

        cmp32("reset_slot_state", 32'(busA.slot_state), 32'h0);
        cmp32("reset_dout_hw_any", 32'(|busA.dout_hw), 32'h0);
        cmp32("reset_dout_sw", busA.dout_sw, 32'h0);

        // Fill slot 0 with 0x1000+k; the top-word write arms it.
        for (int k = 0; k < WPO; k++) begin
            applyStimulus(1'b1, 1'b0, k*WORD_BYTES, 32'h1000 + k, '0, '0);
            tick();
            if (k == WPO - 2) begin
                cmp32("fill_state_loading", 32'(busA.slot_state[1:0]), 32'd1);
                cmp32("fill_no_early_pulse", 32'(busA.dout_hw_valid), 32'd0);
            end
        end
        cmp32("arm_pulse", 32'(busA.dout_hw_valid), 32'b01);
        cmp32("arm_state", 32'(busA.slot_state[1:0]), 32'd2);
        cmp32("arm_word0", busA.dout_hw[31:0], 32'h1000);
        cmp32("arm_word15", busA.dout_hw[511:480], 32'h100F);
        tick();
        cmp32("arm_pulse_single", 32'(busA.dout_hw_valid), 32'd0);

        // Arm slot 1 and return a result into it alone.
        for (int k = 0; k < WPO; k++) begin
            applyStimulus(1'b1, 1'b0, (WPO + k)*WORD_BYTES, 32'h2000 + k, '0, '0);
            tick();
        end
        hw = '0;
        hw[OW +: OW] = {(OW/8){8'hA5}};
        hw[0 +: OW]  = {(OW/8){8'h3C}};
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 2'b10, hw);
        cmp32("indep_ready1", 32'(busA.din_hw_ready[1]), 32'd1);
        tick();
        cmp32("indep_state1", 32'(busA.slot_state[3:2]), 32'd3);
        cmp32("indep_state0", 32'(busA.slot_state[1:0]), 32'd2);
        cmp32("indep_slot0_word0", busA.dout_hw[31:0], 32'h1000);
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, '0, '0);
        tick();
        cmp32("indep_read40", busA.dout_sw, 32'hA5A5A5A5);

        // Collision: software write beats a result on armed slot 0.
        hw = {(NC*OW/8){8'h5A}};
        applyStimulus(1'b1, 1'b0, 32'h08, 32'hDEAD0002, 2'b01, hw);
        cmp32("coll_ready0", 32'(busA.din_hw_ready[0]), 32'd0);
        tick();
        cmp32("coll_state0", 32'(busA.slot_state[1:0]), 32'd1);
        cmp32("coll_word2", busA.dout_hw[95:64], 32'hDEAD0002);
        cmp32("coll_word0_kept", busA.dout_hw[31:0], 32'h1000);

        // Re-arm, take a result, then release it by reading the top word.
        applyStimulus(1'b1, 1'b0, 32'h3C, 32'h100F, '0, '0);
        tick();
        cmp32("rearm_pulse", 32'(busA.dout_hw_valid), 32'b01);
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 2'b01, hw);
        tick();
        cmp32("result_state0", 32'(busA.slot_state[1:0]), 32'd3);
        cmp32("result_word0", busA.dout_hw[31:0], 32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b1, 32'h3C, 32'h0, '0, '0);
        tick();
        cmp32("release_state0", 32'(busA.slot_state[1:0]), 32'd0);
        cmp32("release_read", busA.dout_sw, 32'h5A5A5A5A);
        hw = {(NC*OW/8){8'h77}};
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 2'b01, hw);
        cmp32("idle_ready0", 32'(busA.din_hw_ready[0]), 32'd0);
        tick();
        cmp32("idle_ignore_state", 32'(busA.slot_state[1:0]), 32'd0);
        cmp32("idle_ignore_word0", busA.dout_hw[31:0], 32'h5A5A5A5A);

        // Out-of-range index: write dropped, read returns zero.
        applyStimulus(1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, '0, '0);
        tick();
        cmp32("oor_state", 32'(busA.slot_state), 32'hC);
        cmp32("oor_no_pulse", 32'(busA.dout_hw_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h80, 32'h0, '0, '0);
        tick();
        cmp32("oor_read", busA.dout_sw, 32'h0);

        // Single-word slot: one write arms it straight from idle.
        busB.we_sw = 1'b1; busB.addr_sw = '0; busB.din_sw = 32'hCAFEF00D;
        #1;
        tick();
        cmp32("one_pulse", 32'(busB.dout_hw_valid), 32'd1);
        cmp32("one_state", 32'(busB.slot_state), 32'd2);
        cmp32("one_data", busB.dout_hw, 32'hCAFEF00D);
        busB.din_hw_valid = 1'b1; busB.din_hw = 32'h12345678;
        #1;
        cmp32("one_ready", 32'(busB.din_hw_ready), 32'd1);
        tick();
        cmp32("one_result_state", 32'(busB.slot_state), 32'd3);
        busB.re_sw = 1'b1; busB.addr_sw = '0;
        #1;
        tick();
        cmp32("one_read", busB.dout_sw, 32'h12345678);
        cmp32("one_release_state", 32'(busB.slot_state), 32'd0);

        // Reset partway through loading slot 0.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, k*WORD_BYTES, $urandom, '0, '0);
            tick();
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        cmp32("rst_dout_hw_any", 32'(|busA.dout_hw), 32'h0);
        cmp32("rst_slot_state", 32'(busA.slot_state), 32'h0);
        cmp32("rst_valid", 32'(busA.dout_hw_valid), 32'h0);
        cmp32("rst_ready", 32'(busA.din_hw_ready), 32'h0);
        cmp32("rst_dout_sw", busA.dout_sw, 32'h0);
        cmp32("rst_small_state", 32'(busB.slot_state), 32'h0);
        cmp32("rst_small_dout_sw", busB.dout_sw, 32'h0);

        // Random traffic, biased toward top words so slots arm often.
        for (int c = 0; c < 3000; c++) begin
            int idx;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) idx = int'($urandom_range(0, NC - 1)) * WPO + WPO - 1;
            else if (r == 9) idx = DEPTH + int'($urandom_range(0, 3));
            else idx = int'($urandom_range(0, DEPTH - 1));
            for (int w = 0; w < NC*OW/32; w++) hw[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 499) == 0) resetn = 1'b0;
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), idx*WORD_BYTES,
                          $urandom, NC'($urandom_range(0, 3)), hw);
            tick();
            resetn = 1'b1;
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_xfer_ram.md
# operand_xfer_ram

Parametrised word-to-operand transfer buffer between the 32-bit software register bus and `NUM_CORES` wide-operand Montgomery cores. Software fills one operand slot per core word by word. Each slot is presented to its core in parallel, and the core writes its result back through a valid/ready handshake. Per-slot state tracking replaces the single global "last address written" strobe, so cores load, start and finish independently. Registered software read-back of results is included.

## Interface
Parameters:
- `BRAM_ADDR_WIDTH`, default 10: byte-address width of the software port.
- `NUM_CORES`, default 2: number of slots and cores; 1..8.
- `OPERAND_WIDTH`, default 512: bits per slot; multiple of 32.
- Derived, not a parameter: `WORDS_PER_OP = OPERAND_WIDTH/32`; it must be a power of two.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: synchronous reset, active-low.
- `addr_sw`, in, `BRAM_ADDR_WIDTH`: byte address; bits [1:0] are ignored.
- `din_sw`, in, 32: software write data.
- `we_sw`, in, 1: software write enable.
- `re_sw`, in, 1: software read enable.
- `dout_sw`, out, 32: read data, valid 1 cycle after `re_sw`.
- `dout_hw`, out, `NUM_CORES*OPERAND_WIDTH`: slot i occupies bits [i*OPERAND_WIDTH +: OPERAND_WIDTH].
- `dout_hw_valid`, out, `NUM_CORES`: one-cycle pulse per slot when that slot becomes ARMED.
- `din_hw`, in, `NUM_CORES*OPERAND_WIDTH`: result data, packed like `dout_hw`.
- `din_hw_valid`, in, `NUM_CORES`: per-core result valid.
- `din_hw_ready`, out, `NUM_CORES`: per-slot result accept.
- `slot_state`, out, `2*NUM_CORES`: current state of each slot, for status readback.

## Operation
- Storage is `NUM_CORES*WORDS_PER_OP` words of 32 bits.
- Address decode:
  - word index = `addr_sw>>2`.
  - slot = index / `WORDS_PER_OP`.
  - word = index % `WORDS_PER_OP`.
  - Index ≥ depth: writes are dropped and reads return 0.
- Word 0 of a slot is its least significant 32 bits.
- Each slot runs its own FSM with encoding IDLE=0, LOADING=1, ARMED=2, RESULT=3.
  - IDLE -> LOADING: software write to any word of the slot.
  - LOADING -> ARMED: software write to the slot's highest word. `dout_hw_valid[i]` pulses for 1 cycle.
  - ARMED -> RESULT: `din_hw_valid[i] & din_hw_ready[i]`. The full slot is overwritten with `din_hw[i]`.
  - RESULT -> IDLE: software read of the slot's highest word.
  - Software write in ARMED or RESULT: the word is written and the slot returns to LOADING. A write to the highest word goes straight to ARMED again and re-pulses.
  - A write in IDLE to the highest word goes directly to ARMED (single-word slot case).
- `din_hw_ready[i]` is high only when slot i is ARMED and no software write targets slot i in the same cycle. On collision, software wins; the core holds valid and retries.
- `din_hw_valid[i]` in a state other than ARMED is ignored; no write occurs.
- `we_sw` and `re_sw` in the same cycle: the write is performed, and the read returns the pre-write contents.
- Reset clears all FSMs to IDLE, clears `dout_sw`, `dout_hw_valid` and `din_hw_ready` to 0, and zeroes the memory. `dout_hw` therefore reads 0.
- Reset mid-handshake: the result is discarded, and ready is 0 in the cycle after reset.

## Timing
- Software write: data is visible on `dout_hw` the cycle after `we_sw`.
- `dout_hw_valid` pulses in the same cycle the final word becomes visible.
- Hardware write: accepted on the edge where valid&ready. `slot_state` shows RESULT and `dout_sw` reads return the new data from the next cycle.
- `din_hw_ready` is combinational from slot state and `we_sw`/`addr_sw`. There is no combinational path from `din_hw_valid`.
- Read latency is 1 cycle. `dout_sw` holds its value until the next `re_sw`.
- Slots are fully independent: simultaneous hardware writes on all slots in one cycle are legal.

## Structure
- Package `rsa_xfer_pkg`:
  - slot state enum, 2 bits.
  - `WORD_BYTES=4`.
  - helper function for slot/word decode.
- One natural sub-module, `operand_slot`, instanced `NUM_CORES` times via generate. It holds the `WORDS_PER_OP` word registers, the FSM, the valid pulse and the ready logic.
- The top level contains only address decode, the read mux and the `dout_sw` register.

## Test plan
- **Fill and arm:** `NUM_CORES=2`, `OPERAND_WIDTH=512`. Write words 0..15 with 0x1000+k. Required: `dout_hw[511:0]` = concatenation of those words, one `dout_hw_valid=2'b01` pulse on the cycle after the address-0x3C write, `slot_state[1:0]=2`.
- **Independent result:** slot 1 ARMED. Drive `din_hw_valid=2'b10` with slot 1 data = all 0xA5. Required: `din_hw_ready[1]=1`, RESULT next cycle. A read of 0x40 returns 0xA5A5A5A5 one cycle later. Slot 0 is unchanged.
- **Collision:** slot 0 ARMED. `din_hw_valid[0]=1` in the same cycle as a software write to 0x08. Required: `ready[0]=0`, word 2 takes the software data, slot goes to LOADING, no result is written.
- **Release:** slot 0 in RESULT. Read 0x3C. Required: slot goes to IDLE and `slot_state[1:0]=0`. A further `din_hw_valid[0]` is ignored.
- **Out-of-range and boundary:** write 0x80 with depth 32 words. Required: no state change; reading 0x80 returns 0. Also check `NUM_CORES=1`, `OPERAND_WIDTH=32`: one write arms the slot immediately.
- **Reset mid-load:** after 8 words, assert `resetn=0` for 1 cycle. Required: all outputs 0, all slots IDLE, `dout_hw` all zero.
